// File: rtl/sevenseg_mux_driver.sv
// Time-multiplexed hex 7-segment driver: scans NUM_DIGITS digits with guard time,
// leading-zero suppression and frame-coherent shadow/active register updates.
module sevenseg_mux_driver #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned DIGIT_HZ   = 1000,
  parameter int unsigned GUARD_CYC  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int unsigned DIV = CLK_HZ / DIGIT_HZ;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VW  = 4 * NUM_DIGITS;

  logic [CW-1:0]         slot_cnt;
  logic [IW-1:0]         idx;

  logic [VW-1:0]         sh_value;
  logic [NUM_DIGITS-1:0] sh_dp;
  logic [NUM_DIGITS-1:0] sh_blank;
  logic                  sh_lz;
  logic                  sh_valid;

  logic [VW-1:0]         act_value;
  logic [NUM_DIGITS-1:0] act_dp;
  logic [NUM_DIGITS-1:0] act_blank;
  logic                  act_lz;
  logic                  act_valid;

  logic                  slot_wrap_c;
  logic                  frame_wrap_c;
  logic                  in_guard_c;
  logic                  lz_blank_c;
  logic [3:0]            cur_nib_c;
  logic                  cur_dp_c;
  logic                  cur_blank_c;
  logic                  cur_zero_c;
  logic                  zero_acc_c;
  logic [NUM_DIGITS-1:0] an_nxt_c;
  logic [6:0]            seg_nxt_c;
  logic                  dp_nxt_c;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign slot_wrap_c  = (slot_cnt == CW'(DIV - 1));
  assign frame_wrap_c = slot_wrap_c && (idx == IW'(NUM_DIGITS - 1));
  assign in_guard_c   = (slot_cnt < CW'(GUARD_CYC));

  // Slot counter and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_wrap_c) begin
      slot_cnt <= '0;
      idx      <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      slot_cnt <= slot_cnt + CW'(1);
    end
  end

  // Shadow capture; sh_valid keeps the display dark until something was loaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_value <= '0;
      sh_dp    <= '0;
      sh_blank <= '1;
      sh_lz    <= 1'b0;
      sh_valid <= 1'b0;
    end else if (load) begin
      sh_value <= value;
      sh_dp    <= dp_in;
      sh_blank <= blank_in;
      sh_lz    <= lz_en;
      sh_valid <= 1'b1;
    end
  end

  // Active copy only at the frame boundary, using the pre-load shadow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_value   <= '0;
      act_dp      <= '0;
      act_blank   <= '1;
      act_lz      <= 1'b0;
      act_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_wrap_c;
      if (frame_wrap_c) begin
        act_value <= sh_value;
        act_dp    <= sh_dp;
        act_blank <= sh_blank;
        act_lz    <= sh_lz;
        act_valid <= sh_valid;
      end
    end
  end

  // Select current digit; zero_acc tracks "this digit and all above are zero"
  always_comb begin
    cur_nib_c   = '0;
    cur_dp_c    = 1'b0;
    cur_blank_c = 1'b0;
    cur_zero_c  = 1'b0;
    zero_acc_c  = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_acc_c = zero_acc_c & (act_value[4*i +: 4] == 4'h0);
      if (IW'(i) == idx) begin
        cur_nib_c   = act_value[4*i +: 4];
        cur_dp_c    = act_dp[i];
        cur_blank_c = act_blank[i];
        cur_zero_c  = zero_acc_c;
      end
    end
  end

  assign lz_blank_c = act_lz && (idx != '0) && cur_zero_c;

  always_comb begin
    an_nxt_c  = '1;
    seg_nxt_c = 7'b1111111;
    dp_nxt_c  = 1'b1;
    if (act_valid && !in_guard_c) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (IW'(i) == idx) an_nxt_c[i] = 1'b0;
      end
      if (!(cur_blank_c || lz_blank_c)) begin
        seg_nxt_c = hex_to_seg(cur_nib_c);
        dp_nxt_c  = ~cur_dp_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= '1;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt_c;
      seg <= seg_nxt_c;
      dp  <= dp_nxt_c;
    end
  end

endmodule

// File: tb/tb_sevenseg_mux_driver.sv
// Bench for sevenseg_mux_driver: table of display records checked frame by frame
// through an expected-output queue, plus load-timing and async-reset sequences.
module tb_sevenseg_mux_driver;

  localparam int unsigned ND = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   value = '0;
  logic [ND-1:0] dp_in = '0;
  logic [ND-1:0] blank_in = '0;
  logic          lz_en = 1'b0;
  logic          load = 1'b0;
  logic [ND-1:0] an;
  logic [6:0]    seg;
  logic          dp;
  logic          frame_start;

  sevenseg_mux_driver #(
    .NUM_DIGITS(ND), .CLK_HZ(16), .DIGIT_HZ(4), .GUARD_CYC(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .blank_in(blank_in),
    .lz_en(lz_en), .load(load), .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } obs_t;

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp_in;
    logic [3:0]      blank_in;
    logic            lz_en;
    logic            valid;
    logic [3:0][6:0] seg;
    logic [3:0]      dpn;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  obs_t sb[$];
  vec_t vecs[8];
  vec_t blank_disp;
  vec_t cur;

  function automatic vec_t mk(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                              input logic lz, input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0, input logic [3:0] dpn);
    vec_t r;
    r.value = v; r.dp_in = d; r.blank_in = b; r.lz_en = lz; r.valid = 1'b1;
    r.seg = {s3, s2, s1, s0};
    r.dpn = dpn;
    return r;
  endfunction

  // Expected pins for cycle i (0..15) after a frame_start sample
  function automatic obs_t expect_obs(input vec_t v, input int i);
    obs_t o;
    int d, s;
    logic [3:0] one;
    d = i / 4;
    s = i % 4;
    one = 4'b0001;
    o.fs = (i == 15);
    if (s == 0 || !v.valid) begin
      o.an = 4'hF; o.seg = 7'b1111111; o.dp = 1'b1;
    end else begin
      o.an = ~(one << d); o.seg = v.seg[d]; o.dp = v.dpn[d];
    end
    return o;
  endfunction

  task automatic check(input string name, input int cyc, input obs_t got, input obs_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc %0d: got an=%b seg=%b dp=%b fs=%b, want an=%b seg=%b dp=%b fs=%b",
               name, cyc, got.an, got.seg, got.dp, got.fs, exp.an, exp.seg, exp.dp, exp.fs);
    end
  endtask

  task automatic drive(input vec_t v);
    value = v.value; dp_in = v.dp_in; blank_in = v.blank_in; lz_en = v.lz_en;
    load = 1'b1;
  endtask

  // Checks one 16-cycle frame showing 'show', optionally loading records at given cycles
  task automatic check_frame(input string name, input vec_t show,
                             input int ld_at, input vec_t ld_a,
                             input int ld2_at, input vec_t ld_b);
    obs_t got, e;
    for (int i = 0; i < 16; i++) begin
      load = 1'b0;
      if (i == ld_at) drive(ld_a);
      if (i == ld2_at) drive(ld_b);
      sb.push_back(expect_obs(show, i));
      @(negedge clk);
      got = {an, seg, dp, frame_start};
      e = sb.pop_front();
      check(name, i, got, e);
    end
    load = 1'b0;
  endtask

  initial begin
    obs_t off, got;
    off = {4'hF, 7'b1111111, 1'b1, 1'b0};
    blank_disp = '{value: '0, dp_in: '0, blank_in: '1, lz_en: 1'b0, valid: 1'b0,
                   seg: '1, dpn: '1};
    vecs[0] = mk(16'h12AF, 4'b0000, 4'b0000, 1'b0,
                 7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110, 4'b1111);
    vecs[1] = mk(16'h0005, 4'b0000, 4'b0000, 1'b1,
                 7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010, 4'b1111);
    vecs[2] = mk(16'h0000, 4'b0000, 4'b0000, 1'b1,
                 7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000, 4'b1111);
    vecs[3] = mk(16'h3456, 4'b0100, 4'b0001, 1'b0,
                 7'b0110000, 7'b0011001, 7'b0010010, 7'b1111111, 4'b1011);
    vecs[4] = mk(16'h0789, 4'b1111, 4'b0000, 1'b1,
                 7'b1111111, 7'b1111000, 7'b0000000, 7'b0010000, 4'b1000);
    vecs[5] = mk(16'hBCDE, 4'b0000, 4'b0000, 1'b0,
                 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 4'b1111);
    vecs[6] = mk(16'h0346, 4'b0000, 4'b0000, 1'b0,
                 7'b1000000, 7'b0110000, 7'b0011001, 7'b0000010, 4'b1111);
    vecs[7] = mk(16'h0100, 4'b0000, 4'b0000, 1'b1,
                 7'b1111111, 7'b1111001, 7'b1000000, 7'b1000000, 4'b1111);

    repeat (3) @(negedge clk);
    got = {an, seg, dp, frame_start};
    check("reset", 0, got, off);
    rst_n = 1'b1;

    // No load: dark display, frame_start every 16 cycles
    check_frame("idle0", blank_disp, -1, blank_disp, -1, blank_disp);
    check_frame("idle1", blank_disp, -1, blank_disp, -1, blank_disp);

    // Each frame shows the previous record while loading the next one
    cur = blank_disp;
    for (int k = 0; k < 8; k++) begin
      check_frame($sformatf("vec%0d", k), cur, 0, vecs[k], -1, blank_disp);
      cur = vecs[k];
    end
    check_frame("vec_last", cur, -1, blank_disp, -1, blank_disp);

    // Mid-frame load, then a load coincident with the frame wrap
    check_frame("midload", cur, 5, vecs[0], -1, blank_disp);
    cur = vecs[0];
    check_frame("wrapload", cur, 15, vecs[5], -1, blank_disp);
    check_frame("wrapload_old", cur, -1, blank_disp, -1, blank_disp);
    cur = vecs[5];
    check_frame("wrapload_new", cur, -1, blank_disp, -1, blank_disp);

    // Back-to-back loads: last wins
    check_frame("b2b", cur, 0, vecs[1], 1, vecs[3]);
    cur = vecs[3];
    check_frame("b2b_res", cur, -1, blank_disp, -1, blank_disp);

    // Asynchronous reset between edges while a digit is lit
    cur = vecs[0];
    check_frame("pre_rst", vecs[3], 0, cur, -1, blank_disp);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 got = {an, seg, dp, frame_start};
    check("rst_async", 0, got, off);
    @(negedge clk);
    got = {an, seg, dp, frame_start};
    check("rst_hold", 1, got, off);
    rst_n = 1'b1;
    check_frame("post_rst", blank_disp, 0, cur, -1, blank_disp);
    check_frame("post_rst_show", cur, -1, blank_disp, -1, blank_disp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
